// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_pkg
// Purpose  : Shared constants and types for the 640x480@60 framebuffer
//            scanout path (VGA timing, framebuffer geometry, control bundle).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Framebuffer geometry; each stored pixel covers SCALE x SCALE screen pixels
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int SCALE = 4;

  localparam int CNT_W = 10;
  localparam int COL_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter compare points, pre-sized to the counter width
  localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_END    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_END    = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SYNC_BEGIN = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SYNC_BEGIN = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  // Video control bits that travel together down the output pipeline
  typedef struct packed {
    logic de;
    logic hsync_n;
    logic vsync_n;
  } vid_ctrl_t;

  localparam vid_ctrl_t CTRL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // Half-open range test [lo, hi)
  function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 h/v counters and stage-0 (undelayed) timing flags.
// Ports    : clk, rst          - pixel clock, synchronous active-high reset
//            active            - current (h,v) is inside the visible area
//            hsync_n, vsync_n  - active-low syncs for current (h,v)
//            vblank_start      - high only at h=0, v=480
//            line_end          - h is the last count of the line
//            frame_end         - last cycle of the frame (h=799, v=524)
//            col_step          - last screen pixel of a stored pixel column
//            row_step          - end of the last screen line of a stored row
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_fb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic vblank_start,
  output logic line_end,
  output logic frame_end,
  output logic col_step,
  output logic row_step
);

  cnt_t h;
  cnt_t v;

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + cnt_t'(1);
    end else begin
      h <= h + cnt_t'(1);
    end
  end

  assign line_end     = (h == H_LAST);
  assign frame_end    = line_end && (v == V_LAST);
  assign active       = (h < H_ACT_END) && (v < V_ACT_END);
  assign hsync_n      = !in_range(h, H_SYNC_BEGIN, H_SYNC_END);
  assign vsync_n      = !in_range(v, V_SYNC_BEGIN, V_SYNC_END);
  assign vblank_start = (h == '0) && (v == V_ACT_END);

  // SCALE is a power of two, so the low counter bits give the sub-pixel phase
  assign col_step = active && (h[1:0] == 2'(SCALE - 1));
  assign row_step = line_end && (v < V_ACT_END) && (v[1:0] == 2'(SCALE - 1));

endmodule
`default_nettype wire

// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_reader
// Purpose  : Framebuffer scanout engine. Reads a 160x120 page from a
//            dual-port SRAM (1-cycle registered read) and drives 4x upscaled
//            640x480@60 video with aligned syncs. Supports page flipping.
// Ports    : clk, rst      - pixel clock, synchronous active-high reset
//            fb_select     - page to display, sampled on the last frame cycle
//            read_addr     - SRAM read address (registered, stage 1)
//            read_data     - SRAM read data, valid one cycle after read_addr
//            rgb, de       - pixel and active-video flag (stage 2)
//            hsync_n       - horizontal sync, active-low (stage 2)
//            vsync_n       - vertical sync, active-low (stage 2)
//            vblank_pulse  - one-cycle pulse at h=0, v=480 (stage 0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int A_WIDTH    = 16,
  parameter int PAGE_WORDS = 19200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fb_select,
  output logic [A_WIDTH-1:0] read_addr,
  input  logic [D_WIDTH-1:0] read_data,
  output logic [D_WIDTH-1:0] rgb,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               de,
  output logic               vblank_pulse
);

  logic active;
  logic hsync0_n;
  logic vsync0_n;
  logic vblank_start;
  logic line_end;
  logic frame_end;
  logic col_step;
  logic row_step;

  vga_timing_gen u_timing (
    .clk          (clk),
    .rst          (rst),
    .active       (active),
    .hsync_n      (hsync0_n),
    .vsync_n      (vsync0_n),
    .vblank_start (vblank_start),
    .line_end     (line_end),
    .frame_end    (frame_end),
    .col_step     (col_step),
    .row_step     (row_step)
  );

  logic               page_sel;
  logic [A_WIDTH-1:0] page_base;
  logic [COL_W-1:0]   col;
  logic [A_WIDTH-1:0] row_base;
  vid_ctrl_t          ctrl_s1;
  vid_ctrl_t          ctrl_s2;

  assign page_base = page_sel ? A_WIDTH'(PAGE_WORDS) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      page_sel  <= 1'b0;
      col       <= '0;
      row_base  <= '0;
      read_addr <= '0;
      ctrl_s1   <= CTRL_IDLE;
      ctrl_s2   <= CTRL_IDLE;
    end else begin
      // Page only changes between frames so a frame never tears
      if (frame_end) begin
        page_sel <= fb_select;
      end

      // col/row_base track (h/SCALE) and (v/SCALE)*FB_W incrementally
      if (line_end) begin
        col <= '0;
      end else if (col_step) begin
        col <= col + COL_W'(1);
      end

      if (frame_end) begin
        row_base <= '0;
      end else if (row_step) begin
        row_base <= row_base + A_WIDTH'(FB_W);
      end

      // Address is frozen during blanking so idle SRAM reads are stable
      if (active) begin
        read_addr <= page_base + row_base + A_WIDTH'(col);
      end

      ctrl_s1 <= '{de: active, hsync_n: hsync0_n, vsync_n: vsync0_n};
      ctrl_s2 <= ctrl_s1;
    end
  end

  assign de      = ctrl_s2.de;
  assign hsync_n = ctrl_s2.hsync_n;
  assign vsync_n = ctrl_s2.vsync_n;

  // read_data is already registered inside the SRAM, so it lines up with
  // ctrl_s2 without another flop; the gate blanks stale no-care reads.
  assign rgb = ctrl_s2.de ? read_data : '0;

  // Taken straight from the counters to give the CPU the earliest notice
  assign vblank_pulse = vblank_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_reader
// Purpose  : Self-checking bench for vga_fb_reader with an SRAM whose
//            word[i] = i[7:0].
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fb_select;
  logic [15:0] read_addr;
  logic [7:0]  read_data;
  logic [7:0]  rgb;
  logic        hsync_n;
  logic        vsync_n;
  logic        de;
  logic        vblank_pulse;

  int checks = 0;
  int errors = 0;
  int pos    = 0;   // clock edges since the last reset release
  int vb_cnt = 0;

  vga_fb_reader #(
    .D_WIDTH    (8),
    .A_WIDTH    (16),
    .PAGE_WORDS (19200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fb_select    (fb_select),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .rgb          (rgb),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .de           (de),
    .vblank_pulse (vblank_pulse)
  );

  always #5 clk = ~clk;

  // SRAM read port: registered, one cycle latency, word[i] = i[7:0]
  always @(posedge clk) read_data <= read_addr[7:0];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pos++;
      if (vblank_pulse === 1'b1) vb_cnt++;
    end
  endtask

  task automatic goto(input int target);
    step(target - pos);
  endtask

  function automatic logic [15:0] pix_addr(input int base, input int line, input int h);
    return 16'(base + (line / 4) * 160 + h / 4);
  endfunction

  function automatic string sig_name(input int i);
    case (i)
      0:       return "read_addr";
      1:       return "de";
      2:       return "rgb";
      3:       return "hsync_n";
      4:       return "vsync_n";
      default: return "vblank_pulse";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string when);
    chk({when, " de"},           32'(de),           32'd0);
    chk({when, " rgb"},          32'(rgb),          32'd0);
    chk({when, " hsync_n"},      32'(hsync_n),      32'd1);
    chk({when, " vsync_n"},      32'(vsync_n),      32'd1);
    chk({when, " read_addr"},    32'(read_addr),    32'd0);
    chk({when, " vblank_pulse"}, 32'(vblank_pulse), 32'd0);
  endtask

  // Walks one full line; keeps the first mismatch (or last sample) per signal.
  // At step k: read_addr reflects (h=k-1), outputs reflect (h=k-2), vblank (h=k).
  task automatic check_line(input int fstart, input int line, input int base);
    logic [31:0] o[6];
    logic [31:0] e[6];
    logic [31:0] on[6];
    logic [31:0] en[6];
    bit          bad[6];
    int          at[6];
    int          hs_low;
    int          hp, lp, la, ha;
    goto(fstart + line * 800);
    hs_low = 0;
    for (int i = 0; i < 6; i++) bad[i] = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      step(1);
      la = (line < 480) ? line : 479;
      ha = (line < 480 && k - 1 < 640) ? k - 1 : 639;
      if (k == 1) begin
        hp = 799;
        lp = (line == 0) ? 524 : line - 1;
      end else begin
        hp = k - 2;
        lp = line;
      end
      on[0] = 32'(read_addr);
      en[0] = 32'(pix_addr(base, la, ha));
      on[1] = 32'(de);
      en[1] = (lp < 480 && hp < 640) ? 32'd1 : 32'd0;
      on[2] = 32'(rgb);
      en[2] = (en[1] == 32'd1) ? 32'(pix_addr(base, lp, hp) & 16'h00ff) : 32'd0;
      on[3] = 32'(hsync_n);
      en[3] = (hp >= 656 && hp < 752) ? 32'd0 : 32'd1;
      on[4] = 32'(vsync_n);
      en[4] = (lp == 490 || lp == 491) ? 32'd0 : 32'd1;
      on[5] = 32'(vblank_pulse);
      en[5] = (k == 800 && line == 479) ? 32'd1 : 32'd0;
      if (hsync_n === 1'b0) hs_low++;
      for (int i = 0; i < 6; i++) begin
        if (!bad[i]) begin
          o[i]  = on[i];
          e[i]  = en[i];
          at[i] = k;
          if (on[i] !== en[i]) bad[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("line %0d %s step %0d", line, sig_name(i), at[i]), o[i], e[i]);
    chk($sformatf("line %0d hsync_n low cycles", line), 32'(hs_low), 32'd96);
  endtask

  initial begin
    rst       = 1'b1;
    fb_select = 1'b0;
    step(3);
    check_reset_vals("in reset");

    rst    = 1'b0;
    pos    = 0;
    vb_cnt = 0;
    check_reset_vals("release");

    // Page 0, word per 4 pixels, row base steps by 160 every 4 lines
    check_line(0, 0, 0);
    check_line(0, 4, 0);

    // Pixel (x=5, y=9): word 2*160+1 = 321 -> 0x41
    goto(9 * 800 + 5 + 2);
    chk("pixel(5,9) rgb", 32'(rgb), 32'h41);
    chk("pixel(5,9) de",  32'(de),  32'd1);

    // Mid-frame reset at h=300, v=200 with fb_select high
    goto(200 * 800 + 300);
    fb_select = 1'b1;
    rst       = 1'b1;
    step(1);
    check_reset_vals("mid-frame reset 1");
    step(2);
    check_reset_vals("mid-frame reset 3");
    rst    = 1'b0;
    pos    = 0;
    vb_cnt = 0;
    check_reset_vals("after mid-frame reset");

    // Latched page is 0 after reset even though fb_select is high
    check_line(0, 0, 0);
    check_line(0, 100, 0);
    check_line(0, 479, 0);
    goto(480 * 800 + 100);
    chk("read_addr held in vblank", 32'(read_addr), 32'd19199);
    check_line(0, 490, 0);
    check_line(0, 492, 0);

    goto(524 * 800 + 798);
    chk("vblank pulses in frame", 32'(vb_cnt), 32'd1);
    fb_select = 1'b0;
    step(1);
    fb_select = 1'b1;   // only the last frame cycle carries the new page

    // Next frame begins exactly 420000 cycles in, on page 1
    check_line(420000, 0, 19200);
    check_line(420000, 4, 19200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_reader.md
# vga_fb_reader

Framebuffer scanout engine: the read-side client of the dual-port inferred SRAM that holds the 160x120 framebuffer. Generates 640x480@60 Hz VGA timing, issues one SRAM read address per pixel on a dedicated read port, absorbs the SRAM's 1-cycle registered read latency, and drives 4x-upscaled pixel data plus aligned sync signals to the DAC pins. Also supports double-buffer page flipping and provides a vblank pulse to the CPU.

## Interface
- D_WIDTH, 8: pixel width; must equal the framebuffer SRAM D_WIDTH.
- A_WIDTH, 16: SRAM address width; must hold 2 pages (2 * 19200 words).
- PAGE_WORDS, 19200: words per page (160*120).
- clk  in  1  pixel clock, 25.175 MHz nominal; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fb_select  in  1  page to display; sampled only at frame start.
- read_addr  out  A_WIDTH  SRAM read-port address (registered).
- read_data  in  D_WIDTH  SRAM read-port data, valid 1 cycle after read_addr.
- rgb  out  D_WIDTH  pixel to DAC; 0 outside active video.
- hsync_n  out  1  horizontal sync, active-low.
- vsync_n  out  1  vertical sync, active-low.
- de  out  1  active-video flag aligned with rgb.
- vblank_pulse  out  1  one-cycle pulse at start of vertical blanking.

## Operation
- Horizontal counter h: 0..799; active 0..639, front porch 640..655, sync 656..751, back porch 752..799. Wraps 799->0 and advances v.
- Vertical counter v: 0..524; active 0..479, front porch 480..489, sync 490..491, back porch 492..524. Wraps 524->0.
- Page base: latched from fb_select when h=799 and v=524 (last cycle of frame); base = latched_sel ? PAGE_WORDS : 0. fb_select changes at other times have no effect until next frame.
- Address generation, no multiplier: col (0..159) increments every 4th active pixel; row_base increments by 160 after every 4th active line (v[1:0]==3 at h=799); row_base resets to 0 at frame wrap. Address = page_base + row_base + col.
- Outside active video read_addr holds its last value (no-care reads permitted, but must not change during blanking, to ease sim checking).
- rgb = read_data when delayed de is high, else 0.
- vblank_pulse high for exactly one cycle when counters are at h=0, v=480 (stage 0).
- Reset values: h=0, v=0, read_addr=0, rgb=0, de=0, hsync_n=1, vsync_n=1, vblank_pulse=0, latched page=0. Reset mid-frame aborts the frame; scanout restarts at h=0,v=0 on the first cycle after rst deasserts.

## Timing
- Pipeline depth 2: stage 0 counters (h,v) at cycle t; stage 1 read_addr registered at t+1; stage 2 read_data available, rgb/de/hsync_n/vsync_n registered at t+2.
- All of rgb, de, hsync_n, vsync_n correspond to the same (h,v) from 2 cycles earlier; sync signals are delayed through the same 2-stage shift as de.
- vblank_pulse is not delayed (stage 0 timing) so the CPU gets earliest notice.
- After reset deassert, outputs remain at reset values for 2 cycles (pipeline flush), then follow stage-0 state of h=0,v=0.
- Frame period 800*525 = 420000 cycles; one read address per active pixel, each SRAM word read 4 consecutive times per line, 4 lines per row.

## Structure
- Package vga_fb_pkg: H_ACTIVE/H_FP/H_SYNC/H_BP/H_TOTAL, V_ACTIVE/V_FP/V_SYNC/V_BP/V_TOTAL, FB_W=160, FB_H=120, SCALE=4 localparams.
- Sub-module vga_timing_gen: h/v counters, active/sync/vblank flags (stage 0). vga_fb_reader instantiates it and adds address generation, page latch, and output pipeline.

## Test plan
- Reset then run one full frame -> hsync_n low for 96 cycles per line starting 656+2 cycles after line start; vsync_n low for lines 490-491; exactly 420000 cycles between frames.
- SRAM model with word[i]=i[7:0], fb_select=0 -> pixel (x=5,y=9) rgb = word 2*160+1 = 321 -> 0x41; rgb==0 whenever de==0.
- Check read_addr sequence on line 0: 0,0,0,0,1,1,1,1,...,159 across h=0..639; line 4 starts at 160; last active pixel of frame reads 19199.
- fb_select=1 asserted mid-frame -> current frame addresses stay <19200; next frame starts at 19200 and ends at 38399; toggle back on last frame cycle -> takes effect immediately next frame.
- vblank_pulse -> exactly one cycle per frame, at h=0,v=480, 2 cycles before de of last line would have appeared if extended.
- Assert rst for 3 cycles at h=300,v=200 -> outputs at reset values through 2 cycles after release, then de rises at first pixel of h=0,v=0 with read_addr=0.
